axis2fib_txctrl: RTL and testbench
==================================

Name: axis2fib_txctrl

Overview:
- Transmit-side AXIS bridge: AXIS slave that accepts frames from the user/AXIS master.
- Writes qwords into the TX data FIFO and one 32-bit byte-count/status word per frame into the TX count FIFO.
- The downstream FMAC transmit path consumes a frame only once both FIFOs are non-empty.
- Reset-to-count format matches the RX-side convention: byte count in [31:16].

Parameters:
- DATA_WIDTH, 64, data FIFO word width and AXIS tdata width.
- BCNT_WIDTH, 32, count FIFO word width.
- MAX_BYTES, 16'd9600, largest legal frame in bytes; larger frames are flagged oversize.

Ports:
- tx_mac_aclk  in  1  clock at AXIS frequency.
- reset_  in  1  asynchronous active-low reset.
- tx_axis_mac_tdata  in  64  frame data.
- tx_axis_mac_tvalid  in  1  data valid.
- tx_axis_mac_tlast  in  1  last beat of frame.
- tx_axis_mac_tuser  in  1  upstream error/abort for the frame (sampled on tlast beat).
- tx_axis_mac_tstrb  in  8  valid-byte lanes.
- tx_axis_mac_tready  out  1  bridge can accept a beat.
- bit8_en  in  1  1 = 8-bit mode (one byte per beat, lane 0), 0 = 64-bit mode.
- wralmfull_tf  in  1  data FIFO almost full (asserted with ≤2 free entries).
- wrfull_tcf  in  1  count FIFO full.
- wren_tf  out  1  data FIFO write enable.
- datain_tf  out  64  data FIFO write data.
- wren_tcf  out  1  count FIFO write enable.
- datain_tcf  out  32  count FIFO write data.
- tx_frame_done  out  1  one-cycle pulse when a count word is written.

Behaviour:
- States (one-hot): TX_IDLE, TX_DATA, TX_WRCNT.
- Reset (async, active-low): state=TX_IDLE; every output 0; byte accumulator, error flags and stats cleared. A partial frame in progress is discarded, with no count word written.
- TX_IDLE:
  - tready=0.
  - Go to TX_DATA when !wralmfull_tf & !wrfull_tcf.
- TX_DATA:
  - tready = !wralmfull_tf, combinational from registered state and flag.
  - Beat accepted when tvalid & tready.
  - On acceptance, next cycle: wren_tf=1, datain_tf=tdata. Latency is exactly 1 cycle; no write without acceptance.
- Byte accumulator (16 bits):
  - 64-bit mode adds popcount(tstrb) per accepted beat.
  - 8-bit mode adds 1 per beat and ignores tstrb.
  - Saturates at 16'hFFFF.
- tstrb legality (64-bit mode):
  - Non-last beats must be 8'hFF.
  - The last beat must be contiguous from bit 0 (01,03,07,0F,1F,3F,7F,FF).
  - A violation sets strb_err; the count is still the popcount.
- Oversize: accumulator > MAX_BYTES sets ovs_err. Beats continue to be accepted and written, so frame alignment is preserved.
- Accepted beat with tlast → TX_WRCNT. tready=0 from the next cycle.
- TX_WRCNT (one cycle):
  - wren_tcf=1, tx_frame_done=1.
  - datain_tcf = {bytecnt[15:0], 13'h0, ovs_err, strb_err, tuser_at_tlast}.
  - Then clear the accumulator and flags → TX_IDLE.
  - The count word write coincides with the last data write, so the count is never visible before its data.
- tvalid without tlast can persist indefinitely. Deasserting tvalid mid-frame stalls; nothing is written.
- wralmfull_tf rising mid-frame drops tready the same cycle. The in-flight registered write still lands, which the ≤2-free-entries threshold covers.
- Zero-length frames cannot occur: a tlast beat is always ≥1 byte. A 64-bit tlast beat with tstrb=0 counts 0 and sets strb_err.

Optional Feature:
- Macro AXIS2FIB_TX_STATS_EN.
- When defined:
  - Adds outputs tx_frame_cnt[31:0] and tx_err_cnt[31:0], wrapping counters, reset 0.
  - tx_frame_cnt increments on every TX_WRCNT.
  - tx_err_cnt increments when any of the three status bits is set.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package axis2fib_pkg:
  - State encodings.
  - Count-word field offsets (BCNT_MSB=31, BCNT_LSB=16, OVS_BIT=2, STRB_BIT=1, TUSER_BIT=0).
  - Legal-tstrb constants.
- One sub-module: axis2fib_strb_chk, combinational popcount plus contiguity check returning {count[3:0], legal}.

Test Plan:
- 64-bit frame of 3 beats, tstrb FF,FF,0F, tlast on beat 3 → three wren_tf pulses; wren_tcf with datain_tcf=32'h0014_0000; tx_frame_done once.
- bit8_en=1, 5 beats → datain_tcf=32'h0005_0000; tstrb ignored.
- Mid-frame beat tstrb=8'h7F (non-last), frame total 23 bytes → datain_tcf=32'h0017_0002.
- wralmfull_tf asserted for 4 cycles mid-frame → tready low those cycles; no lost or duplicated wren_tf; final count is correct.
- reset_ pulsed low after 2 beats of a frame → all outputs 0 immediately; no count word; the next clean 1-beat frame with tstrb=01 gives datain_tcf=32'h0001_0000.
- Frame of MAX_BYTES+8 bytes with tuser=1 on tlast → all beats written; datain_tcf[2:0]=3'b101.

Source files
------------

// File: rtl/axis2fib_pkg.sv
// axis2fib_pkg: shared definitions for the AXIS-to-FIFO transmit bridge.
//   - one-hot FSM state encodings
//   - count-word field offsets (byte count in [31:16], status in [2:0])
//   - legal tstrb patterns and the count-word packing helper
package axis2fib_pkg;

  localparam logic [2:0] TX_IDLE  = 3'b001;
  localparam logic [2:0] TX_DATA  = 3'b010;
  localparam logic [2:0] TX_WRCNT = 3'b100;

  localparam int BCNT_MSB  = 31;
  localparam int BCNT_LSB  = 16;
  localparam int OVS_BIT   = 2;
  localparam int STRB_BIT  = 1;
  localparam int TUSER_BIT = 0;

  localparam logic [7:0] STRB_FULL = 8'hFF;

  // Last-beat strobes must be contiguous from lane 0.
  localparam logic [7:0] STRB_LEGAL [8] = '{8'h01, 8'h03, 8'h07, 8'h0F,
                                            8'h1F, 8'h3F, 8'h7F, 8'hFF};

  function automatic logic [31:0] pack_cnt(input logic [15:0] cnt,
                                           input logic ovs, input logic strb,
                                           input logic tuser);
    logic [31:0] w;
    w = '0;
    w[BCNT_MSB:BCNT_LSB] = cnt;
    w[OVS_BIT]           = ovs;
    w[STRB_BIT]          = strb;
    w[TUSER_BIT]         = tuser;
    return w;
  endfunction

endpackage

// File: rtl/axis2fib_strb_chk.sv
// axis2fib_strb_chk: combinational tstrb analysis.
//   strb  in  8  byte-lane strobes of the current beat
//   res   out 5  {popcount[3:0], legal}; legal = strobe is a contiguous
//                run starting at lane 0 (valid as a last-beat pattern)
module axis2fib_strb_chk
  import axis2fib_pkg::*;
(
  input  logic [7:0] strb,
  output logic [4:0] res
);

  logic [3:0] cnt;
  logic       legal;

  always_comb begin
    cnt   = '0;
    legal = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, strb[i]};
      if (strb == STRB_LEGAL[i]) legal = 1'b1;
    end
    res = {cnt, legal};
  end

endmodule

// File: rtl/axis2fib_txctrl.sv
// axis2fib_txctrl: transmit-side AXIS slave feeding the TX data FIFO (one
// qword per accepted beat) and the TX count FIFO (one status word per frame).
// Ports:
//   tx_mac_aclk, reset_           clock, async active-low reset
//   tx_axis_mac_t*                AXIS slave (tdata/tvalid/tlast/tuser/tstrb/tready)
//   bit8_en                       1 = one byte per beat on lane 0
//   wralmfull_tf, wrfull_tcf      FIFO backpressure flags
//   wren_tf/datain_tf             data FIFO write port (1 cycle after accept)
//   wren_tcf/datain_tcf           count FIFO write port
//   tx_frame_done                 pulse with each count-word write
// Optional macro AXIS2FIB_TX_STATS_EN adds tx_frame_cnt / tx_err_cnt.
module axis2fib_txctrl
  import axis2fib_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          BCNT_WIDTH = 32,
  parameter logic [15:0] MAX_BYTES  = 16'd9600
) (
  input  logic                  tx_mac_aclk,
  input  logic                  reset_,
  input  logic [DATA_WIDTH-1:0] tx_axis_mac_tdata,
  input  logic                  tx_axis_mac_tvalid,
  input  logic                  tx_axis_mac_tlast,
  input  logic                  tx_axis_mac_tuser,
  input  logic [7:0]            tx_axis_mac_tstrb,
  output logic                  tx_axis_mac_tready,
  input  logic                  bit8_en,
  input  logic                  wralmfull_tf,
  input  logic                  wrfull_tcf,
  output logic                  wren_tf,
  output logic [DATA_WIDTH-1:0] datain_tf,
  output logic                  wren_tcf,
  output logic [BCNT_WIDTH-1:0] datain_tcf,
  output logic                  tx_frame_done
`ifdef AXIS2FIB_TX_STATS_EN
  , output logic [31:0]         tx_frame_cnt
  , output logic [31:0]         tx_err_cnt
`endif
);

  logic [2:0]  state;
  logic [15:0] bytecnt;
  logic        ovs_err, strb_err, tuser_q;

  logic [4:0]  chk_res;
  logic [3:0]  strb_cnt;
  logic        strb_legal;
  logic        beat, strb_bad;
  logic [16:0] sum;
  logic [15:0] next_cnt;
  logic        in_wrcnt;

  axis2fib_strb_chk u_strb_chk (.strb(tx_axis_mac_tstrb), .res(chk_res));

  assign strb_cnt   = chk_res[4:1];
  assign strb_legal = chk_res[0];

  assign tx_axis_mac_tready = (state == TX_DATA) && !wralmfull_tf;
  assign beat               = tx_axis_mac_tvalid && tx_axis_mac_tready;

  assign sum      = {1'b0, bytecnt} + (bit8_en ? 17'd1 : {13'd0, strb_cnt});
  assign next_cnt = sum[16] ? 16'hFFFF : sum[15:0];

  // Middle beats must be full; the last beat must be a lane-0 run.
  assign strb_bad = !bit8_en &&
                    (tx_axis_mac_tlast ? !strb_legal : (tx_axis_mac_tstrb != STRB_FULL));

  // The count word is driven straight from state so it lands in the same
  // cycle as the registered write of the frame's last qword.
  assign in_wrcnt      = (state == TX_WRCNT);
  assign wren_tcf      = in_wrcnt;
  assign tx_frame_done = in_wrcnt;
  assign datain_tcf    = in_wrcnt ? BCNT_WIDTH'(pack_cnt(bytecnt, ovs_err, strb_err, tuser_q))
                                  : '0;

  always_ff @(posedge tx_mac_aclk or negedge reset_) begin
    if (!reset_) begin
      state     <= TX_IDLE;
      wren_tf   <= 1'b0;
      datain_tf <= '0;
      bytecnt   <= '0;
      ovs_err   <= 1'b0;
      strb_err  <= 1'b0;
      tuser_q   <= 1'b0;
    end else begin
      wren_tf <= 1'b0;
      case (state)
        TX_IDLE: if (!wralmfull_tf && !wrfull_tcf) state <= TX_DATA;
        TX_DATA: if (beat) begin
          wren_tf   <= 1'b1;
          datain_tf <= tx_axis_mac_tdata;
          bytecnt   <= next_cnt;
          if (strb_bad)             strb_err <= 1'b1;
          if (next_cnt > MAX_BYTES) ovs_err  <= 1'b1;
          if (tx_axis_mac_tlast) begin
            tuser_q <= tx_axis_mac_tuser;
            state   <= TX_WRCNT;
          end
        end
        TX_WRCNT: begin
          bytecnt  <= '0;
          ovs_err  <= 1'b0;
          strb_err <= 1'b0;
          tuser_q  <= 1'b0;
          state    <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

`ifdef AXIS2FIB_TX_STATS_EN
  always_ff @(posedge tx_mac_aclk or negedge reset_) begin
    if (!reset_) begin
      tx_frame_cnt <= '0;
      tx_err_cnt   <= '0;
    end else if (in_wrcnt) begin
      tx_frame_cnt <= tx_frame_cnt + 32'd1;
      if (ovs_err || strb_err || tuser_q) tx_err_cnt <= tx_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis2fib_txctrl.sv
// Directed bench for axis2fib_txctrl: frames with hand-computed count words.
module tb_axis2fib_txctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] tdata;
  logic        tvalid, tlast, tuser;
  logic [7:0]  tstrb;
  logic        tready;
  logic        bit8_en, almfull, wrfull_tcf;
  logic        wren_tf, wren_tcf, frame_done;
  logic [63:0] datain_tf;
  logic [31:0] datain_tcf;

  always #5 clk = ~clk;

  axis2fib_txctrl dut (
    .tx_mac_aclk(clk), .reset_(rst_n),
    .tx_axis_mac_tdata(tdata), .tx_axis_mac_tvalid(tvalid),
    .tx_axis_mac_tlast(tlast), .tx_axis_mac_tuser(tuser),
    .tx_axis_mac_tstrb(tstrb), .tx_axis_mac_tready(tready),
    .bit8_en(bit8_en), .wralmfull_tf(almfull), .wrfull_tcf(wrfull_tcf),
    .wren_tf(wren_tf), .datain_tf(datain_tf),
    .wren_tcf(wren_tcf), .datain_tcf(datain_tcf),
    .tx_frame_done(frame_done)
  );

  int n_chk = 0, n_pass = 0;

  // Output monitor, sampled on the falling edge.
  int          tf_cnt = 0, tcf_cnt = 0, done_cnt = 0;
  logic [63:0] tf_log [0:2047];
  logic [31:0] tcf_word = '0;
  logic        tcf_coinc = 1'b0;

  always @(negedge clk) begin
    if (wren_tf) begin
      tf_log[tf_cnt[10:0]] = datain_tf;
      tf_cnt++;
    end
    if (wren_tcf) begin
      tcf_word  = datain_tcf;
      tcf_coinc = wren_tf;
      tcf_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [63:0] d, input logic [7:0] s,
                           input logic l, input logic u);
    bit ok = 0;
    tdata = d; tstrb = s; tlast = l; tuser = u; tvalid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (tready) ok = 1;
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic wait_tcf(input int base);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #1;
      if (tcf_cnt > base) ok = 1;
    end
    if (!ok) chk("tcf_timeout", 32'd0, 32'd1);
  endtask

  int b_tf, b_tcf, b_done;

  task automatic snap();
    b_tf = tf_cnt; b_tcf = tcf_cnt; b_done = done_cnt;
  endtask

  initial begin
    rst_n = 1'b0; tdata = '0; tvalid = 0; tlast = 0; tuser = 0; tstrb = '0;
    bit8_en = 0; almfull = 0; wrfull_tcf = 0;
    #23;
    chk("rst_tready",  {31'd0, tready},     32'd0);
    chk("rst_wren_tf", {31'd0, wren_tf},    32'd0);
    chk("rst_tcf",     {31'd0, wren_tcf},   32'd0);
    chk("rst_done",    {31'd0, frame_done}, 32'd0);
    chk("rst_dtcf",    datain_tcf,          32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 3-beat 64-bit frame: 8+8+4 = 20 bytes.
    snap();
    send_beat(64'h1111_0000_0000_0001, 8'hFF, 0, 0);
    send_beat(64'h2222_0000_0000_0002, 8'hFF, 0, 0);
    send_beat(64'h3333_0000_0000_0003, 8'h0F, 1, 0);
    wait_tcf(b_tcf);
    chk("f1_tcf",   tcf_word, 32'h0014_0000);
    chk("f1_ntf",   tf_cnt - b_tf, 3);
    chk("f1_d0",    tf_log[b_tf][31:0],   32'h0000_0001);
    chk("f1_d1",    tf_log[b_tf+1][63:32], 32'h2222_0000);
    chk("f1_d2",    tf_log[b_tf+2][63:32], 32'h3333_0000);
    chk("f1_ntcf",  tcf_cnt - b_tcf, 1);
    chk("f1_ndone", done_cnt - b_done, 1);
    chk("f1_coinc", {31'd0, tcf_coinc}, 32'd1);

    // 8-bit mode, 5 beats, strobes ignored.
    bit8_en = 1; snap();
    send_beat(64'h41, 8'h00, 0, 0);
    send_beat(64'h42, 8'h3C, 0, 0);
    send_beat(64'h43, 8'hFF, 0, 0);
    send_beat(64'h44, 8'h80, 0, 0);
    send_beat(64'h45, 8'h00, 1, 0);
    wait_tcf(b_tcf);
    chk("b8_tcf", tcf_word, 32'h0005_0000);
    chk("b8_ntf", tf_cnt - b_tf, 5);
    bit8_en = 0;

    // Partial middle beat: 8+7+8 = 23 bytes, strobe error.
    snap();
    send_beat(64'hA1, 8'hFF, 0, 0);
    send_beat(64'hA2, 8'h7F, 0, 0);
    send_beat(64'hA3, 8'hFF, 1, 0);
    wait_tcf(b_tcf);
    chk("strb_tcf", tcf_word, 32'h0017_0002);

    // Almost-full for 4 cycles with a beat pending: 8*3+2 = 26 bytes.
    snap();
    send_beat(64'hB1, 8'hFF, 0, 0);
    send_beat(64'hB2, 8'hFF, 0, 0);
    tdata = 64'hB3; tstrb = 8'hFF; tvalid = 1'b1; almfull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("af_tready", {31'd0, tready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("af_stall_ntf", tf_cnt - b_tf, 2);
    almfull = 1'b0;
    send_beat(64'hB3, 8'hFF, 0, 0);
    send_beat(64'hB4, 8'h03, 1, 0);
    wait_tcf(b_tcf);
    chk("af_tcf", tcf_word, 32'h001A_0000);
    chk("af_ntf", tf_cnt - b_tf, 4);
    chk("af_d2",  tf_log[b_tf+2][31:0], 32'h0000_00B3);
    chk("af_d3",  tf_log[b_tf+3][31:0], 32'h0000_00B4);

    // Reset mid-frame: everything clears at once, no count word.
    snap();
    send_beat(64'hC1, 8'hFF, 0, 0);
    send_beat(64'hC2, 8'hFF, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_wren_tf", {31'd0, wren_tf}, 32'd0);
    chk("mrst_dtf",     datain_tf[31:0],  32'd0);
    chk("mrst_tready",  {31'd0, tready},  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_ntcf", tcf_cnt - b_tcf, 0);
    snap();
    send_beat(64'hD1, 8'h01, 1, 0);
    wait_tcf(b_tcf);
    chk("mrst_next_tcf", tcf_word, 32'h0001_0000);

    // Oversize: 1201 full beats = 9608 bytes, tuser on last.
    snap();
    for (int i = 0; i < 1201; i++)
      send_beat(64'(i), 8'hFF, (i == 1200), (i == 1200));
    wait_tcf(b_tcf);
    chk("ovs_tcf", tcf_word, 32'h2588_0005);
    chk("ovs_ntf", tf_cnt - b_tf, 1201);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
